// File: rtl/systolic_feeder_pkg.sv
// Shared constants and state encoding for the systolic-array operand feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package systolic_feeder_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int LANES      = 8;
    localparam int WORD_WIDTH = DATA_WIDTH * LANES;

    // 1 read latency + 1 capture register + 7 skew stages on the deepest lane.
    localparam int FEED_DRAIN = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } feed_state_e;

endpackage

// File: rtl/systolic_feeder_skew_line.sv
// Per-lane delay line used to diagonally skew operand lanes.
// Latency: DEPTH cycles (DEPTH=0 is a wire).
// Backpressure: none; free-running shift register.
module skew_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_pass
        assign q_o = d_i;
    end else begin : g_sr
        logic [WIDTH-1:0] sr_q [DEPTH];

        // Shift one stage per cycle; reset flushes any in-flight beats.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
            end else begin
                sr_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
            end
        end

        assign q_o = sr_q[DEPTH-1];
    end

endmodule

// File: rtl/systolic_feeder.sv
// Reads one K-long tile from the A/B buffers and emits lane-skewed words plus clear/we.
// Latency: start at S, lane i of beat k at S+3+k+i, done_o at S+K+10 (S+1 when K=0).
// Backpressure: none; consumer must accept every beat, start_i ignored unless idle.
module systolic_feeder
    import systolic_feeder_pkg::*;
#(
    parameter int AW = 9,
    parameter int KW = 9
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [KW-1:0]         k_i,
    input  logic [AW-1:0]         a_base_i,
    input  logic [AW-1:0]         b_base_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  a_en_o,
    output logic                  b_en_o,
    output logic [AW-1:0]         a_addr_o,
    output logic [AW-1:0]         b_addr_o,
    input  logic [WORD_WIDTH-1:0] a_word_i,
    input  logic [WORD_WIDTH-1:0] b_word_i,
    output logic [WORD_WIDTH-1:0] srca_word_o,
    output logic [WORD_WIDTH-1:0] srcb_word_o,
    output logic                  clear_o,
    output logic                  we_o
);

    feed_state_e           state_q, state_d;
    logic [KW-1:0]         k_q;
    logic [KW-1:0]         cnt_q;
    logic [AW-1:0]         a_base_q, b_base_q;
    logic [3:0]            drain_q;
    logic                  rd_en;
    logic                  issue_last;
    logic                  rd_vld_q, rd_first_q, rd_last_q;
    logic                  cap_first_q, cap_last_q;
    logic [WORD_WIDTH-1:0] cap_a_q, cap_b_q;

    assign issue_last = (cnt_q == k_q - KW'(1));

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state: a zero-length tile skips straight to DONE without touching the buffers.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_i) state_d = (k_i == '0) ? ST_DONE : ST_FETCH;
            ST_FETCH: if (issue_last) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_q == 4'd0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; addresses are forced to 0 while not reading.
    always_comb begin
        busy_o   = (state_q != ST_IDLE);
        done_o   = (state_q == ST_DONE);
        rd_en    = (state_q == ST_FETCH);
        a_en_o   = rd_en;
        b_en_o   = rd_en;
        a_addr_o = rd_en ? a_base_q + AW'(cnt_q) : '0;
        b_addr_o = rd_en ? b_base_q + AW'(cnt_q) : '0;
    end

    // Tile parameters are latched at start so the inputs may change during the tile.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            k_q      <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
            cnt_q    <= '0;
            drain_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: if (start_i) begin
                    k_q      <= k_i;
                    a_base_q <= a_base_i;
                    b_base_q <= b_base_i;
                    cnt_q    <= '0;
                end
                ST_FETCH: begin
                    cnt_q <= cnt_q + KW'(1);
                    if (issue_last) drain_q <= 4'(FEED_DRAIN - 1);
                end
                ST_DRAIN: drain_q <= drain_q - 4'd1;
                default: ;
            endcase
        end
    end

    // Tag each issued read so first/last line up with the data returning a cycle later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_vld_q   <= 1'b0;
            rd_first_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            rd_vld_q   <= rd_en;
            rd_first_q <= rd_en && (cnt_q == '0);
            rd_last_q  <= rd_en && issue_last;
        end
    end

    // Capture returned words; bubbles become zeros so downstream accumulation is unaffected.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cap_a_q     <= '0;
            cap_b_q     <= '0;
            cap_first_q <= 1'b0;
            cap_last_q  <= 1'b0;
        end else begin
            cap_a_q     <= rd_vld_q ? a_word_i : '0;
            cap_b_q     <= rd_vld_q ? b_word_i : '0;
            cap_first_q <= rd_first_q;
            cap_last_q  <= rd_last_q;
        end
    end

    // clear/we travel with lane 0, which has no extra skew.
    assign clear_o = cap_first_q;
    assign we_o    = cap_last_q;

    assign srca_word_o[DATA_WIDTH-1:0] = cap_a_q[DATA_WIDTH-1:0];
    assign srcb_word_o[DATA_WIDTH-1:0] = cap_b_q[DATA_WIDTH-1:0];

    for (genvar i = 1; i < LANES; i++) begin : g_lane
        skew_line #(.DEPTH(i), .WIDTH(DATA_WIDTH)) u_skew_a (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .d_i    (cap_a_q[i*DATA_WIDTH +: DATA_WIDTH]),
            .q_o    (srca_word_o[i*DATA_WIDTH +: DATA_WIDTH])
        );
        skew_line #(.DEPTH(i), .WIDTH(DATA_WIDTH)) u_skew_b (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .d_i    (cap_b_q[i*DATA_WIDTH +: DATA_WIDTH]),
            .q_o    (srcb_word_o[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: buffer model plus a per-cycle schedule model of one tile.
// Latency: n/a.
// Backpressure: n/a.
module tb_systolic_feeder;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         start_i;
    logic [8:0]   k_i;
    logic [8:0]   a_base_i, b_base_i;
    logic         busy_o, done_o, a_en_o, b_en_o, clear_o, we_o;
    logic [8:0]   a_addr_o, b_addr_o;
    logic [127:0] a_word_i, b_word_i;
    logic [127:0] srca_word_o, srcb_word_o;

    systolic_feeder #(.AW(9), .KW(9)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .k_i         (k_i),
        .a_base_i    (a_base_i),
        .b_base_i    (b_base_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .a_en_o      (a_en_o),
        .b_en_o      (b_en_o),
        .a_addr_o    (a_addr_o),
        .b_addr_o    (b_addr_o),
        .a_word_i    (a_word_i),
        .b_word_i    (b_word_i),
        .srca_word_o (srca_word_o),
        .srcb_word_o (srcb_word_o),
        .clear_o     (clear_o),
        .we_o        (we_o)
    );

    always #5 clk_i = ~clk_i;

    logic [127:0] mem_a [512];
    logic [127:0] mem_b [512];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model of the current tile: start cycle, length, bases.
    bit t_on = 0;
    int t_s, t_k, t_ab, t_bb;

    bit         req_a, req_b;
    logic [8:0] req_a_addr, req_b_addr;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Expected skewed word: lane i shows beat k = d-3-i when that beat exists.
    function automatic logic [127:0] exp_skew(input bit is_b, input int d);
        logic [127:0] w;
        logic [127:0] m;
        int k;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            k = d - 3 - i;
            if (k >= 0 && k < t_k) begin
                m = is_b ? mem_b[(t_bb + k) % 512] : mem_a[(t_ab + k) % 512];
                w[16*i +: 16] = m[16*i +: 16];
            end
        end
        return w;
    endfunction

    task automatic check_outputs();
        int  d, dur;
        bit  e_busy, e_done, e_en, e_clr, e_we;
        logic [127:0] e_sa, e_sb;
        logic [8:0] e_aa, e_ba;
        e_busy = 0; e_done = 0; e_en = 0; e_clr = 0; e_we = 0;
        e_sa = '0; e_sb = '0; e_aa = '0; e_ba = '0;
        if (t_on && rst_ni) begin
            d   = cyc - t_s;
            dur = (t_k == 0) ? 1 : t_k + 10;
            e_busy = (d >= 1 && d <= dur);
            e_done = (d == dur);
            e_en   = (t_k > 0 && d >= 1 && d <= t_k);
            e_clr  = (t_k > 0 && d == 3);
            e_we   = (t_k > 0 && d == t_k + 2);
            e_aa   = 9'((t_ab + d - 1) % 512);
            e_ba   = 9'((t_bb + d - 1) % 512);
            e_sa   = exp_skew(1'b0, d);
            e_sb   = exp_skew(1'b1, d);
        end
        chk("busy",  128'(busy_o),  128'(e_busy));
        chk("done",  128'(done_o),  128'(e_done));
        chk("a_en",  128'(a_en_o),  128'(e_en));
        chk("b_en",  128'(b_en_o),  128'(e_en));
        chk("clear", 128'(clear_o), 128'(e_clr));
        chk("we",    128'(we_o),    128'(e_we));
        chk("srca",  srca_word_o,   e_sa);
        chk("srcb",  srcb_word_o,   e_sb);
        if (e_en || !rst_ni) begin
            chk("a_addr", 128'(a_addr_o), 128'(e_en ? e_aa : 9'd0));
            chk("b_addr", 128'(b_addr_o), 128'(e_en ? e_ba : 9'd0));
        end
    endtask

    // One clock: check at negedge, then answer reads one cycle later like the buffers.
    task automatic cycle();
        @(negedge clk_i);
        check_outputs();
        req_a = a_en_o; req_a_addr = a_addr_o;
        req_b = b_en_o; req_b_addr = b_addr_o;
        @(posedge clk_i);
        cyc++;
        #1;
        a_word_i = req_a ? mem_a[req_a_addr] : rnd128();
        b_word_i = req_b ? mem_b[req_b_addr] : rnd128();
    endtask

    task automatic idle(input int n);
        start_i = 0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Runs a whole tile; returns in the cycle after done_o so a restart can follow at once.
    task automatic run_tile(input int k, input int ab, input int bb, input bit poke);
        int dur;
        start_i = 1; k_i = 9'(k); a_base_i = 9'(ab); b_base_i = 9'(bb);
        t_on = 1; t_s = cyc; t_k = k; t_ab = ab; t_bb = bb;
        dur = (k == 0) ? 1 : k + 10;
        cycle();
        while (cyc <= t_s + dur) begin
            k_i = 9'($urandom); a_base_i = 9'($urandom); b_base_i = 9'($urandom);
            start_i = poke && (cyc == t_s + 2 || cyc == t_s + k + 3);
            cycle();
        end
        start_i = 0;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem_a[i] = rnd128();
            mem_b[i] = rnd128();
        end
        rst_ni = 0; start_i = 0; k_i = '0; a_base_i = '0; b_base_i = '0;
        a_word_i = '0; b_word_i = '0;
        idle(3);
        rst_ni = 1;
        idle(2);

        // K=1 with recognisable lane patterns.
        for (int i = 0; i < 8; i++) begin
            mem_a[16][16*i +: 16] = 16'(16'h0010 + i);
            mem_b[32][16*i +: 16] = 16'(16'h0020 + i);
        end
        run_tile(1, 16, 32, 0);
        idle(2);

        // K=4 with words 1..4 in every lane.
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 8; i++) mem_a[100 + k][16*i +: 16] = 16'(k + 1);
        run_tile(4, 100, 200, 0);
        idle(1);

        // K=0: straight to done, no reads.
        run_tile(0, 5, 6, 0);
        idle(2);

        // Address wrap on both buffers.
        run_tile(4, 9'h1FE, 9'h1FD, 0);
        idle(1);

        // Starts during FETCH and DRAIN are ignored; immediate restart after done.
        run_tile(6, 40, 300, 1);
        run_tile(3, 77, 78, 0);
        run_tile(0, 1, 2, 0);
        run_tile(2, 9'h1FF, 0, 1);
        idle(2);

        // Reset in the middle of a K=8 fetch aborts the tile.
        start_i = 1; k_i = 9'd8; a_base_i = 9'd50; b_base_i = 9'd60;
        t_on = 1; t_s = cyc; t_k = 8; t_ab = 50; t_bb = 60;
        cycle();
        start_i = 0;
        idle(3);
        rst_ni = 0; t_on = 0;
        idle(3);
        rst_ni = 1;
        idle(20);
        run_tile(2, 123, 321, 0);
        idle(2);

        // Random tiles, some back-to-back, some with stray starts.
        for (int n = 0; n < 12; n++) begin
            run_tile($urandom_range(0, 20), $urandom_range(0, 511),
                     $urandom_range(0, 511), 1'($urandom));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Upstream stage of the 8×8 systolic array. It reads operand words from the A and B global buffers for one K-length dot-product tile and emits them diagonally skewed: lane i is delayed i cycles. The skewed A word drives the first `pe_array`'s `srca_word_i`, and lane j of the skewed B word drives `srcb_i` of `pe_array` j. The block also generates the `clear`/`we` control pulses for `pe_array` 0, aligned with the first and last beats.

## Interface
Parameters:
- `AW`, 9: global-buffer address width.
- `KW`, 9: width of the K (inner-dimension) count.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. One clock; reset is asynchronous and active-low.
- `start_i` in 1: start a tile. Sampled only in IDLE.
- `k_i` in KW: tile length K. Latched at start.
- `a_base_i`, `b_base_i` in AW each: first read address in each buffer. Latched at start.
- `busy_o` out 1: high from the cycle after start until `done_o`, inclusive.
- `done_o` out 1: one-cycle pulse at tile end.
- `a_en_o`, `b_en_o` out 1: buffer read enables.
- `a_addr_o`, `b_addr_o` out AW: buffer read addresses.
- `a_word_i`, `b_word_i` in `WORD_WIDTH`: read data, valid 1 cycle after the enable.
- `srca_word_o` out `WORD_WIDTH`: skewed A word to `pe_array` 0.
- `srcb_word_o` out `WORD_WIDTH`: skewed B lanes, lane j to `pe_array` j.
- `clear_o`, `we_o` out 1: control to `pe_array` 0.

## Operation
- States and transitions:
  - IDLE → FETCH on `start_i` with `k_i`≠0.
  - IDLE → DONE on `start_i` with `k_i`=0. No reads, no clear/we.
  - FETCH issues K reads, one per cycle, at addresses base+0 … base+K−1. `a_en_o` = `b_en_o` = 1; A and B share a counter k. FETCH → DRAIN after the beat k=K−1.
  - DRAIN holds for 9 cycles (1 read latency + 1 output register + 7 skew). A down-counter drives it. DRAIN → DONE.
  - DONE asserts `done_o` for 1 cycle, then → IDLE.
- Address arithmetic is modulo 2^AW. base+k wraps silently.
- Capture: one cycle after each issue, the returned words are registered together with a valid bit and `first`/`last` tags. `first` marks k=0; `last` marks k=K−1.
- Skew:
  - Lane i (16-bit slice `DATA`i) of both A and B passes through i extra register stages. Lane 0 has 0 extra stages; lane 7 has 7.
  - Lanes whose beat is invalid carry 0. Zero bubbles are harmless to accumulation.
- `clear_o` is high in the cycle when lane 0 carries beat k=0. `we_o` is high in the cycle when lane 0 carries beat k=K−1. For K=1, both are high in the same cycle.
  - `pe_array` propagates both signals down the chain with matching skew.
- `start_i` while not IDLE is ignored. `k_i`/base inputs may change freely after start.
- Asserting `rst_ni` mid-tile aborts the tile:
  - All registers clear, skew lines included.
  - State goes to IDLE.
  - No `done_o` is issued.
- Reset value of every output is 0.

## Timing
- Start sampled at cycle S. The first read issues at S+1.
- Beat k issues at S+1+k.
- Lane i of beat k appears at S+3+k+i.
- `clear_o` at S+3. `we_o` at S+2+K.
- Last read at S+K. DRAIN covers S+K+1 … S+K+9. `done_o` at S+K+10.
- Lane 7 of the last beat appears at S+K+9.
- K=0: `done_o` at S+1. `busy_o` is high only in S+1.
- A new start can be accepted in the cycle after `done_o`.

## Structure
- `def.v` owns `WORD_WIDTH`, `DATA_WIDTH` and `DATA0`…`DATA7` (existing macros).
- Add `FEED_DRAIN` (=9) to `def.v`.
- Add state encodings IDLE/FETCH/DRAIN/DONE to `def.v`.
- One sub-module, `skew_line`:
  - Parameters `DEPTH` and `WIDTH`.
  - An async-reset shift register, with DEPTH=0 as a pass-through.
  - Instantiated 7× per operand for lanes 1–7.

## Test plan
- K=1, A lane i = 0x0010+i, B lane j = 0x0020+j, start at S:
  - reads at S+1.
  - `clear_o` and `we_o` both high at S+3.
  - `srca_word_o` lane i = 0x0010+i only at S+3+i.
  - `done_o` at S+11.
- K=4, A words 1..4 per lane:
  - `clear_o` at S+3, `we_o` at S+6.
  - lane 7 carries 1,2,3,4 at S+10..S+13 and 0 otherwise.
- K=0:
  - `done_o` at S+1.
  - `a_en_o`, `clear_o`, `we_o` never high.
- `a_base_i`=0x1FE with K=4:
  - `a_addr_o` sequence 0x1FE, 0x1FF, 0x000, 0x001.
- `start_i` pulsed again during FETCH and during DRAIN:
  - ignored; exactly one `done_o`.
  - immediate restart the cycle after `done_o` is accepted.
- `rst_ni` low during FETCH of a K=8 tile:
  - all outputs 0 within the reset.
  - no `done_o`.
  - a subsequent K=2 tile behaves per the timing above.
